// File: rtl/fft_frame_seq.sv
// fft_frame_seq: buffers one streamed frame and replays it as a gap-free FFT core burst.
// Optional zero padding of short frames is enabled by defining FFT_SEQ_ZERO_PAD_EN.
module fft_frame_seq #(
  parameter int TOTAL_STEP   = 6,
  parameter int DATA_WIDTH   = 16,
  parameter int MAX_INFLIGHT = 2,
  parameter int ID_WIDTH     = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_real,
  input  logic [DATA_WIDTH-1:0] s_imag,
  input  logic                  s_last,
  output logic                  core_ien,
  output logic [DATA_WIDTH-1:0] core_ireal,
  output logic [DATA_WIDTH-1:0] core_iimag,
  input  logic                  core_oen,
  input  logic [DATA_WIDTH-1:0] core_oreal,
  input  logic [DATA_WIDTH-1:0] core_oimag,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_real,
  output logic [DATA_WIDTH-1:0] m_imag,
  output logic                  m_last,
  output logic [ID_WIDTH-1:0]   m_id,
  output logic                  err_short,
  output logic                  err_long,
  output logic                  err_orphan,
  output logic [1:0]            inflight
);
  localparam int N  = 1 << TOTAL_STEP;
  localparam int AW = TOTAL_STEP;
  localparam int SW = 2 * DATA_WIDTH;
  localparam logic [AW-1:0] LAST = '1;
  localparam logic [1:0] MAXF = 2'(MAX_INFLIGHT);

  typedef enum logic [2:0] {
    IDLE, FILL, PAD, DISCARD, HOLD, BURST
  } state_t;

  state_t state_q, state_d;

  logic [AW-1:0] wc_q, wc_d;
  logic [AW-1:0] rc_q, rc_d;
  logic [AW-1:0] oc_q, oc_d;
  logic [1:0]    inf_q, inf_d;

  logic                  ien_q, ien_d;
  logic [DATA_WIDTH-1:0] ire_q, ire_d;
  logic [DATA_WIDTH-1:0] iim_q, iim_d;

  logic                  mv_q, mv_d;
  logic [DATA_WIDTH-1:0] mre_q, mre_d;
  logic [DATA_WIDTH-1:0] mim_q, mim_d;
  logic                  ml_q, ml_d;
  logic [ID_WIDTH-1:0]   mid_q, mid_d;

  logic es_q, es_d;
  logic el_q, el_d;
  logic eo_q, eo_d;

  logic          we;
  logic [AW-1:0] waddr;
  logic [SW-1:0] wdata;
  logic [AW-1:0] raddr;
  logic [SW-1:0] rdata;
  logic          orphan;
  logic          fin;
  logic          start;

  logic [SW-1:0] mem [N];

  always_ff @(posedge i_clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

  always_comb begin
    state_d = state_q;
    wc_d    = wc_q;
    rc_d    = rc_q;
    we      = 1'b0;
    waddr   = wc_q;
    wdata   = {s_real, s_imag};
    raddr   = '0;
    s_ready = 1'b0;
    es_d    = 1'b0;
    el_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_d = FILL;
        wc_d    = '0;
      end
      FILL: begin
        s_ready = 1'b1;
        if (s_valid) begin
          we = 1'b1;
          if (wc_q == LAST) begin
            wc_d = '0;
            if (s_last) begin
              state_d = HOLD;
            end else begin
              el_d    = 1'b1;
              state_d = DISCARD;
            end
          end else if (s_last) begin
            es_d = 1'b1;
`ifdef FFT_SEQ_ZERO_PAD_EN
            wc_d    = wc_q + 1'b1;
            state_d = PAD;
`else
            wc_d    = '0;
`endif
          end else begin
            wc_d = wc_q + 1'b1;
          end
        end
      end
      PAD: begin
        we    = 1'b1;
        wdata = '0;
        if (wc_q == LAST) begin
          wc_d    = '0;
          state_d = HOLD;
        end else begin
          wc_d = wc_q + 1'b1;
        end
      end
      DISCARD: begin
        s_ready = 1'b1;
        if (s_valid && s_last) state_d = HOLD;
      end
      HOLD: begin
        rc_d = '0;
        if (inf_q != MAXF) state_d = BURST;
      end
      BURST: begin
        // address runs one ahead of the registered core data
        raddr = rc_q + 1'b1;
        if (rc_q == LAST) begin
          rc_d    = '0;
          wc_d    = '0;
          state_d = FILL;
        end else begin
          rc_d = rc_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ien_d  = (state_d == BURST);
    ire_d  = ien_d ? rdata[SW-1:DATA_WIDTH] : '0;
    iim_d  = ien_d ? rdata[DATA_WIDTH-1:0] : '0;
    start  = (state_q == HOLD) && (state_d == BURST);
    orphan = core_oen && (inf_q == 2'd0);
    fin    = core_oen && !orphan && (oc_q == LAST);
    oc_d   = oc_q;
    if (core_oen && !orphan) oc_d = fin ? '0 : oc_q + 1'b1;
    inf_d  = inf_q + {1'b0, start} - {1'b0, fin};
    mv_d   = core_oen;
    mre_d  = core_oen ? core_oreal : '0;
    mim_d  = core_oen ? core_oimag : '0;
    ml_d   = fin;
    mid_d  = ml_q ? mid_q + 1'b1 : mid_q;
    eo_d   = orphan;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      wc_q    <= '0;
      rc_q    <= '0;
      oc_q    <= '0;
      inf_q   <= '0;
      ien_q   <= 1'b0;
      ire_q   <= '0;
      iim_q   <= '0;
      mv_q    <= 1'b0;
      mre_q   <= '0;
      mim_q   <= '0;
      ml_q    <= 1'b0;
      mid_q   <= '0;
      es_q    <= 1'b0;
      el_q    <= 1'b0;
      eo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wc_q    <= wc_d;
      rc_q    <= rc_d;
      oc_q    <= oc_d;
      inf_q   <= inf_d;
      ien_q   <= ien_d;
      ire_q   <= ire_d;
      iim_q   <= iim_d;
      mv_q    <= mv_d;
      mre_q   <= mre_d;
      mim_q   <= mim_d;
      ml_q    <= ml_d;
      mid_q   <= mid_d;
      es_q    <= es_d;
      el_q    <= el_d;
      eo_q    <= eo_d;
    end
  end

  assign core_ien   = ien_q;
  assign core_ireal = ire_q;
  assign core_iimag = iim_q;
  assign m_valid    = mv_q;
  assign m_real     = mre_q;
  assign m_imag     = mim_q;
  assign m_last     = ml_q;
  assign m_id       = mid_q;
  assign err_short  = es_q;
  assign err_long   = el_q;
  assign err_orphan = eo_q;
  assign inflight   = inf_q;

endmodule

// File: tb/tb_fft_frame_seq.sv
// tb_fft_frame_seq: random frames into fft_frame_seq, echo core model,
// frame-level reference for bursts, output framing, inflight and errors.
module tb_fft_frame_seq;
  localparam int DW   = 16;
  localparam int IDW  = 4;
  localparam int N    = 64;
  localparam int MAXF = 2;

  typedef logic [2*DW-1:0] smp_t;

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic [DW-1:0] s_real = '0;
  logic [DW-1:0] s_imag = '0;
  logic          s_ready;
  logic          core_ien;
  logic [DW-1:0] core_ireal, core_iimag;
  logic          core_oen = 1'b0;
  logic [DW-1:0] core_oreal = '0;
  logic [DW-1:0] core_oimag = '0;
  logic          m_valid, m_last;
  logic [DW-1:0] m_real, m_imag;
  logic [IDW-1:0] m_id;
  logic          err_short, err_long, err_orphan;
  logic [1:0]    inflight;

  fft_frame_seq #(
    .TOTAL_STEP(6), .DATA_WIDTH(DW),
    .MAX_INFLIGHT(MAXF), .ID_WIDTH(IDW)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_real(s_real), .s_imag(s_imag), .s_last(s_last),
    .core_ien(core_ien), .core_ireal(core_ireal),
    .core_iimag(core_iimag), .core_oen(core_oen),
    .core_oreal(core_oreal), .core_oimag(core_oimag),
    .m_valid(m_valid), .m_real(m_real), .m_imag(m_imag),
    .m_last(m_last), .m_id(m_id),
    .err_short(err_short), .err_long(err_long),
    .err_orphan(err_orphan), .inflight(inflight)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge i_clk) cyc++;

  // reference state
  smp_t exp_q[$];
  smp_t cur[$];
  logic [2*DW:0] dl [0:255];
  int   lat = 10;
  bit   in_burst = 0;
  bit   abort = 0;
  int   started = 0, done_f = 0, prev_inf = 0, max_inf = 0;
  int   oc_m = 0, id_m = 0;
  bit   pend_v = 0, pend_orph = 0;
  smp_t pend_d = '0;
  int   n_short = 0, n_long = 0, n_orph = 0;
  int   x_short = 0, x_long = 0;
  bit   lat_pend = 0;
  int   done_cyc = 0, exp_lat = 2;
  bit   man_req = 0;
  smp_t man_d = '0;
  bit   exp_last, new_start;
  int   nbad;
  smp_t e;

  always @(negedge i_clk) begin
    exp_last  = 0;
    new_start = 0;
    if (pend_v || m_valid) begin
      chk("m_valid", m_valid, pend_v);
      if (pend_v) begin
        chk("m_data", {m_real, m_imag}, pend_d);
        chk("m_id", m_id, id_m & 15);
        if (pend_orph) begin
          chk("m_last_orphan", m_last, 0);
        end else begin
          exp_last = (oc_m == N - 1);
          chk("m_last", m_last, exp_last);
          oc_m = exp_last ? 0 : oc_m + 1;
        end
      end
    end
    if (pend_orph || err_orphan) chk("err_orphan", err_orphan, pend_orph);
    if (err_orphan === 1'b1) n_orph++;
    if (err_short === 1'b1) n_short++;
    if (err_long === 1'b1) n_long++;
    if (exp_last) begin
      done_f++;
      id_m++;
    end
    if (core_ien === 1'b1) begin
      if (!in_burst) begin
        in_burst  = 1;
        new_start = 1;
        cur.delete();
        chk("hold_gate", prev_inf < MAXF, 1);
        started++;
        if (started - done_f > max_inf) max_inf = started - done_f;
        if (lat_pend) begin
          chk("burst_lat", cyc - done_cyc, exp_lat);
          lat_pend = 0;
        end
      end
      cur.push_back({core_ireal, core_iimag});
    end else if (in_burst) begin
      in_burst = 0;
      if (abort) begin
        abort = 0;
        repeat (N) if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else begin
        chk("burst_len", cur.size(), N);
        nbad = 0;
        for (int i = 0; i < N; i++) begin
          if (exp_q.size() == 0) nbad++;
          else begin
            e = exp_q.pop_front();
            if (i >= cur.size() || cur[i] !== e) nbad++;
          end
        end
        chk("burst_data", nbad, 0);
      end
    end
    if (exp_last || new_start) chk("inflight", inflight, started - done_f);
    // echo core: output equals input delayed by lat cycles
    for (int i = 255; i > 0; i--) dl[i] = dl[i-1];
    dl[0] = {core_ien === 1'b1, core_ireal, core_iimag};
    if (man_req) begin
      core_oen = 1'b1;
      {core_oreal, core_oimag} = man_d;
      man_req = 0;
    end else begin
      core_oen = dl[lat][2*DW];
      {core_oreal, core_oimag} = dl[lat][2*DW-1:0];
    end
    pend_v    = core_oen;
    pend_d    = {core_oreal, core_oimag};
    pend_orph = core_oen && (started - done_f == 0);
    if (i_reset) begin
      for (int i = 0; i < 256; i++) dl[i] = '0;
      started = 0; done_f = 0; oc_m = 0; id_m = 0;
      pend_v = 0; pend_orph = 0; core_oen = 1'b0;
    end
    prev_inf = started - done_f;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_frame(input int len, input int gmax, input bit lchk);
    smp_t d;
    smp_t fr[$];
    int w;
    for (int i = 0; i < len; i++) begin
      repeat ($urandom_range(0, gmax)) begin
        s_valid = 1'b0;
        tick();
      end
      d = {DW'($urandom), DW'($urandom)};
      s_valid = 1'b1;
      {s_real, s_imag} = d;
      s_last = (i == len - 1);
      if (i < N) fr.push_back(d);
      w = 0;
      while (s_ready !== 1'b1 && w < 4000) begin
        tick();
        w++;
      end
      if (w >= 4000) begin
        chk("hs_timeout", w, 0);
        s_valid = 1'b0;
        s_last = 1'b0;
        return;
      end
      tick();
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    if (len < N) begin
      x_short++;
`ifdef FFT_SEQ_ZERO_PAD_EN
      while (fr.size() < N) fr.push_back('0);
      exp_lat = 2 + N - len;
      foreach (fr[i]) exp_q.push_back(fr[i]);
      lat_pend = lchk;
      done_cyc = cyc - 1;
`endif
    end else begin
      if (len > N) x_long++;
      exp_lat = 2;
      foreach (fr[i]) exp_q.push_back(fr[i]);
      lat_pend = lchk;
      done_cyc = cyc - 1;
    end
    tick();
    tick();
    chk("err_short_cnt", n_short, x_short);
    chk("err_long_cnt", n_long, x_long);
  endtask

  task automatic wait_quiet();
    int w = 0;
    while ((exp_q.size() != 0 || started != done_f || in_burst)
           && w < 20000) begin
      tick();
      w++;
    end
    chk("drain", w < 20000, 1);
    repeat (5) tick();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_core_ien"}, core_ien, 0);
    chk({tag, "_core_data"}, {core_ireal, core_iimag}, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_data"}, {m_real, m_imag, m_last}, 0);
    chk({tag, "_m_id"}, m_id, 0);
    chk({tag, "_errs"}, {err_short, err_long, err_orphan}, 0);
    chk({tag, "_inflight"}, inflight, 0);
  endtask

  int w0;
  int len;

  initial begin
    for (int i = 0; i < 256; i++) dl[i] = '0;
    i_reset = 1'b1;
    repeat (3) tick();
    check_reset("rst");
    i_reset = 1'b0;
    chk("s_ready_c1", s_ready, 0);
    tick();
    chk("s_ready_c2", s_ready, 1);

    // full frame, idle core
    send_frame(N, 0, 1);
    wait_quiet();

    // long core latency: third frame must wait in HOLD
    lat = 200;
    repeat (3) send_frame(N, 0, 0);
    wait_quiet();
    chk("max_inflight_hold", max_inf, MAXF);
    lat = 10;

    // short frame then a normal frame
    send_frame(40, 0, 1);
    wait_quiet();
    send_frame(N, 1, 1);
    wait_quiet();

    // long frame: extra samples discarded
    send_frame(70, 0, 1);
    wait_quiet();

    // orphan core output
    man_d = {DW'($urandom), DW'($urandom)};
    man_req = 1;
    repeat (4) tick();
    chk("orphan_cnt", n_orph, 1);
    send_frame(N, 0, 1);
    wait_quiet();

    // reset in the middle of a burst
    send_frame(N, 0, 0);
    w0 = 0;
    while (!(in_burst && cur.size() == 30) && w0 < 2000) begin
      tick();
      w0++;
    end
    chk("mid_burst_reached", w0 < 2000, 1);
    abort = 1;
    i_reset = 1'b1;
    tick();
    check_reset("mid_rst");
    i_reset = 1'b0;
    tick();
    send_frame(N, 0, 0);
    wait_quiet();

    // randomized frames
    repeat (3) begin
      lat = $urandom_range(3, 60);
      repeat (6) begin
        case ($urandom_range(0, 5))
          3: len = $urandom_range(1, N - 1);
          4: len = $urandom_range(N + 1, N + 26);
          default: len = N;
        endcase
        send_frame(len, $urandom_range(0, 3), 0);
      end
      wait_quiet();
    end

    chk("inflight_le_max", max_inf <= MAXF, 1);
    chk("err_short_final", n_short, x_short);
    chk("err_long_final", n_long, x_long);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
